abs_pipe: RTL and testbench



---
 rtl/abs_pkg.sv | 22 ++
 rtl/prefix_inc.sv | 41 ++++
 rtl/abs_pipe.sv | 170 +++++++++++++++++
 tb/tb_abs_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/abs_pkg.sv
// Shared types and constants for the pipelined absolute-value unit.
package abs_pkg;

    // Operation select, captured together with each operand.
    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_ABS  = 2'b01,
        MODE_NEG  = 2'b10,
        MODE_SABS = 2'b11
    } abs_mode_e;

    // Most-negative two's-complement value of an n-bit word, right-aligned in 64 bits.
    function automatic logic [63:0] abs_most_neg(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Maximum positive two's-complement value of an n-bit word, right-aligned in 64 bits.
    function automatic logic [63:0] abs_max_pos(input int n);
        return abs_most_neg(n) - 64'd1;
    endfunction

endpackage

// File: rtl/prefix_inc.sv
// Sklansky parallel-prefix incrementer: s = a + cin (mod 2^W), cout = carry out of bit W-1.
// Instantiated with W >= 2 only.
module prefix_inc #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    localparam int LV = (W > 1) ? $clog2(W) : 1;

    // pre[i] = &a[i:0]; the AND-propagate term of every prefix
    logic [W-1:0] pre;
    // carry[i] = carry into bit i
    logic [W-1:0] carry;

    // Sklansky tree: at level l, every bit with index bit l set joins the
    // last bit of the lower half of its 2^(l+1)-wide block.
    always_comb begin
        logic [W-1:0] cur;
        logic [W-1:0] nxt;
        cur = a;
        nxt = a;
        for (int l = 0; l < LV; l++) begin
            nxt = cur;
            for (int i = 0; i < W; i++) begin
                if (((i >> l) & 1) == 1) begin
                    nxt[i] = cur[i] & cur[((i >> l) << l) - 1];
                end
            end
            cur = nxt;
        end
        pre = cur;
    end

    assign carry = {pre[W-2:0], 1'b1} & {W{cin}};
    assign s     = a ^ carry;
    assign cout  = cin & pre[W-1];

endmodule

// File: rtl/abs_pipe.sv
// Pipelined pass / abs / negate / saturating-abs unit with valid/ready on both sides.
// The conditional invert is done at the input; the increment is either done in
// one register stage or split at bit N/2 across two stages.
module abs_pipe
    import abs_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_ovf
);
    localparam logic [N-1:0] MAX_POS = N'(abs_max_pos(N));

    // Replace an overflowed SABS result by the largest positive value.
    function automatic logic [N-1:0] sat_fn(input logic [N-1:0] sum, input logic sat);
        return sat ? MAX_POS : sum;
    endfunction

    // Signed overflow of adding the increment: carry into the MSB differs from
    // the carry out. Carry into the MSB is recovered as op_msb ^ sum_msb.
    // Only the most-negative operand negated can trigger it; negating zero
    // carries out of the MSB as well and correctly reports no overflow.
    function automatic logic ovf_fn(input logic op_msb, input logic sum_msb, input logic cout);
        return op_msb ^ sum_msb ^ cout;
    endfunction

    // ---- stage 0: decode mode, conditional invert ----
    abs_mode_e           mode_p0;
    logic signed [N-1:0] opnd_p0;
    logic                inv_p0;
    logic                sabs_p0;
    logic [N-1:0]        x_p0;

    assign mode_p0 = abs_mode_e'(in_mode);
    assign opnd_p0 = in_data;
    assign inv_p0  = (mode_p0 == MODE_ABS || mode_p0 == MODE_SABS) ? opnd_p0[N-1]
                                                                    : (mode_p0 == MODE_NEG);
    assign sabs_p0 = (mode_p0 == MODE_SABS);
    assign x_p0    = in_data ^ {N{inv_p0}};

    generate
        if (STAGES == 2) begin : g_split
            localparam int LO_W = N / 2;
            localparam int HI_W = N - LO_W;

            logic [LO_W-1:0] lo_sum_p0;
            logic            lo_cout_p0;

            prefix_inc #(.W(LO_W)) u_inc_lo (
                .a    (x_p0[LO_W-1:0]),
                .cin  (inv_p0),
                .s    (lo_sum_p0),
                .cout (lo_cout_p0)
            );

            logic            vld_p1;
            logic            vld_p2;
            logic            acc_p1;
            logic            acc_p2;
            logic [HI_W-1:0] hi_x_p1;
            logic [LO_W-1:0] lo_sum_p1;
            logic            carry_p1;
            logic            sabs_p1;
            logic [HI_W-1:0] hi_sum_p1;
            logic            hi_cout_p1;
            logic            ovf_p1;
            logic [N-1:0]    data_p2;
            logic            ovf_p2;

            // Pass-through ready chain: a stage takes new data when empty or draining.
            assign acc_p2   = !vld_p2 || out_ready;
            assign acc_p1   = !vld_p1 || acc_p2;
            assign in_ready = acc_p1;

            // Stage valid bits; reset discards everything in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1 <= 1'b0;
                    vld_p2 <= 1'b0;
                end else begin
                    if (acc_p1) vld_p1 <= in_valid;
                    if (acc_p2) vld_p2 <= vld_p1;
                end
            end

            // ---- stage 1: upper inverted half, low-half sum and its carry ----
            always_ff @(posedge clk) begin
                if (acc_p1 && in_valid) begin
                    hi_x_p1   <= x_p0[N-1:LO_W];
                    lo_sum_p1 <= lo_sum_p0;
                    carry_p1  <= lo_cout_p0;
                    sabs_p1   <= sabs_p0;
                end
            end

            prefix_inc #(.W(HI_W)) u_inc_hi (
                .a    (hi_x_p1),
                .cin  (carry_p1),
                .s    (hi_sum_p1),
                .cout (hi_cout_p1)
            );

            assign ovf_p1 = ovf_fn(hi_x_p1[HI_W-1], hi_sum_p1[HI_W-1], hi_cout_p1);

            // ---- stage 2: full result, saturated when requested ----
            always_ff @(posedge clk) begin
                if (acc_p2 && vld_p1) begin
                    data_p2 <= sat_fn({hi_sum_p1, lo_sum_p1}, sabs_p1 && ovf_p1);
                    ovf_p2  <= ovf_p1;
                end
            end

            assign out_valid = vld_p2;
            assign out_data  = vld_p2 ? data_p2 : '0;
            assign out_ovf   = vld_p2 && ovf_p2;
        end else begin : g_single
            logic [N-1:0] sum_p0;
            logic         cout_p0;
            logic         ovf_p0;

            prefix_inc #(.W(N)) u_inc (
                .a    (x_p0),
                .cin  (inv_p0),
                .s    (sum_p0),
                .cout (cout_p0)
            );

            assign ovf_p0 = ovf_fn(x_p0[N-1], sum_p0[N-1], cout_p0);

            logic         vld_p1;
            logic         acc_p1;
            logic [N-1:0] data_p1;
            logic         ovf_p1;

            assign acc_p1   = !vld_p1 || out_ready;
            assign in_ready = acc_p1;

            // Single stage valid bit; reset discards the operand in flight.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p1 <= 1'b0;
                end else if (acc_p1) begin
                    vld_p1 <= in_valid;
                end
            end

            // ---- stage 1: full result, saturated when requested ----
            always_ff @(posedge clk) begin
                if (acc_p1 && in_valid) begin
                    data_p1 <= sat_fn(sum_p0, sabs_p0 && ovf_p0);
                    ovf_p1  <= ovf_p0;
                end
            end

            assign out_valid = vld_p1;
            assign out_data  = vld_p1 ? data_p1 : '0;
            assign out_ovf   = vld_p1 && ovf_p1;
        end
    endgenerate

endmodule

// File: tb/tb_abs_pipe.sv
// Directed-vector bench for abs_pipe (N=16, STAGES=2).
module tb_abs_pipe;
    import abs_pkg::*;

    localparam int N      = 16;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic [1:0]   in_mode = 2'b00;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_data;
    logic         out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    abs_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operand through an idle pipeline with out_ready held high.
    task automatic run_one(input string tag, input abs_mode_e m, input logic [N-1:0] d,
                           input logic [N-1:0] exp_d, input logic exp_o);
        int lat;
        in_mode   = m;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val({tag, "_rdy"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check_val({tag, "_lat"}, 64'(lat), 64'(STAGES));
        check_val({tag, "_data"}, 64'(out_data), 64'(exp_d));
        check_val({tag, "_ovf"}, 64'(out_ovf), 64'(exp_o));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int idx;
        int got;
        logic [N-1:0] held;

        // Reset held for 3 cycles with an operand offered.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0005;
        in_mode   = MODE_ABS;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_vld", 64'(out_valid), 64'd0);
            check_val("rst_data", 64'(out_data), 64'd0);
            check_val("rst_ovf", 64'(out_ovf), 64'd0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_val("post_rst_rdy", 64'(in_ready), 64'd1);
        step();

        // Modes
        run_one("abs_fffb", MODE_ABS,  16'hFFFB, 16'h0005, 1'b0);
        run_one("neg_0005", MODE_NEG,  16'h0005, 16'hFFFB, 1'b0);
        run_one("pass_8000", MODE_PASS, 16'h8000, 16'h8000, 1'b0);
        run_one("neg_0000", MODE_NEG,  16'h0000, 16'h0000, 1'b0);
        run_one("abs_0007", MODE_ABS,  16'h0007, 16'h0007, 1'b0);

        // Overflow at the most-negative value
        run_one("abs_8000", MODE_ABS,  16'h8000, 16'h8000, 1'b1);
        run_one("neg_8000", MODE_NEG,  16'h8000, 16'h8000, 1'b1);
        run_one("sabs_8000", MODE_SABS, 16'h8000, 16'h7FFF, 1'b1);
        run_one("sabs_8001", MODE_SABS, 16'h8001, 16'h7FFF, 1'b0);

        // Carry crossing the bit-8 split
        run_one("abs_ff00", MODE_ABS,  16'hFF00, 16'h0100, 1'b0);
        run_one("neg_0100", MODE_NEG,  16'h0100, 16'hFF00, 1'b0);

        // Backpressure: stream 1..8 in ABS, out_ready low in cycles 3..6
        cyc  = 0;
        idx  = 1;
        got  = 0;
        held = '0;
        while (got < 8 && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (idx <= 8);
            in_data   = N'(idx);
            in_mode   = MODE_ABS;
            #1;
            if (cyc == 3) held = out_data;
            if (cyc >= 4 && cyc <= 6) begin
                check_val("bp_stall_vld", 64'(out_valid), 64'd1);
                check_val("bp_stall_data", 64'(out_data), 64'(held));
                check_val("bp_stall_rdy", 64'(in_ready), 64'd0);
            end
            if (out_valid && out_ready) begin
                got++;
                check_val("bp_data", 64'(out_data), 64'(got));
            end
            if (in_valid && in_ready) idx++;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check_val("bp_count", 64'(got), 64'd8);
        check_val("bp_sent", 64'(idx), 64'd9);
        check_val("bp_held", 64'(held), 64'd2);
        #1;
        check_val("bp_drain", 64'(out_valid), 64'd0);
        step();

        // Reset with two operands in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = MODE_ABS;
        in_data   = 16'h0003;
        step();
        in_data = 16'hFFFE;
        step();
        in_valid = 1'b0;
        check_val("mid_full", 64'(out_valid), 64'd1);
        check_val("mid_full_data", 64'(out_data), 64'h0003);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_vld", 64'(out_valid), 64'd0);
        check_val("mid_rst_data", 64'(out_data), 64'd0);
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("post_rst_idle", 64'(out_valid), 64'd0);
        end
        run_one("post_rst_abs", MODE_ABS, 16'hFFF9, 16'h0007, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
